// File: rtl/dualmem_req_bridge_if.sv
// Request/response and RAM-port bundle for dualmem_req_bridge.
// The slave modport is the bridge's view. The master modport is the environment's
// view: the bus adaptor upstream and the dual-port RAM downstream.
interface dualmem_req_bridge_if #(
  parameter int unsigned ADDR_W = 11
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [7:0]        req_be;
  logic [63:0]       req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [63:0]       rsp_rdata;
  logic              rsp_write;

  logic [7:0]        ram_en;
  logic [7:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [63:0]       ram_wdata;
  logic [63:0]       ram_rdata;

  modport slave (
    input  req_valid, req_addr, req_we, req_be, req_wdata, rsp_ready, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_write, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output req_valid, req_addr, req_we, req_be, req_wdata, rsp_ready, ram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_write, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/dualmem_req_bridge.sv
// Valid/ready request front end for one port of the 2048x64 byte-enabled dual-port RAM.
// Reads are tracked through an in-flight pipeline matching the RAM latency. Every response
// lands in a small FIFO, so a stalled consumer never loses read data.
// Optional feature: define DUALMEM_OUTREG_EN when the RAM output register is in use.
// Read latency is then 2 and the in-flight pipeline has two stages.
module dualmem_req_bridge #(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned RSP_DEPTH = 4
) (
  input logic                 clk,
  input logic                 rstn,
  dualmem_req_bridge_if.slave bus
);

`ifdef DUALMEM_OUTREG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  localparam int unsigned      PTR_W    = $clog2(RSP_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);
  localparam logic [4:0]       DEPTH_C  = 5'(RSP_DEPTH);

  logic [LAT-1:0]       r_pipe_vld, r_pipe_wr;
  logic [LAT-1:0]       w_pipe_vld_d, w_pipe_wr_d;
  logic [63:0]          r_fifo_data [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] r_fifo_wr;
  logic [PTR_W-1:0]     r_wptr, r_rptr;
  logic [4:0]           r_count;

  logic [4:0]        w_outstanding;
  logic              w_ready, w_accept, w_push, w_pop, w_rsp_valid;
  logic [63:0]       w_push_data;
  logic [ADDR_W-1:0] w_addr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit: everything that will eventually need a FIFO slot counts as outstanding
  always_comb begin
    w_outstanding = r_count;
    for (int i = 0; i < int'(LAT); i++) begin
      w_outstanding = w_outstanding + 5'(r_pipe_vld[i]);
    end
  end

  assign w_ready     = rstn && (w_outstanding < DEPTH_C);
  assign w_accept    = bus.req_valid && w_ready;
  assign w_rsp_valid = rstn && (r_count != 5'd0);
  assign w_pop       = w_rsp_valid && bus.rsp_ready;
  assign w_push      = r_pipe_vld[LAT-1];
  assign w_push_data = r_pipe_wr[LAT-1] ? 64'd0 : bus.ram_rdata;
  assign w_addr      = bus.req_addr;

  // RAM drive and response outputs, gated so that nothing leaks while rstn is low
  always_comb begin
    bus.req_ready = w_ready;
    bus.ram_addr  = w_addr;
    bus.ram_wdata = bus.req_wdata;
    bus.ram_en    = 8'h00;
    bus.ram_we    = 8'h00;
    if (w_accept) begin
      if (bus.req_we) begin
        bus.ram_en = bus.req_be;
        bus.ram_we = bus.req_be;
      end else begin
        bus.ram_en = 8'hFF;
      end
    end
    bus.rsp_valid = w_rsp_valid;
    bus.rsp_rdata = w_rsp_valid ? r_fifo_data[r_rptr] : 64'd0;
    bus.rsp_write = w_rsp_valid ? r_fifo_wr[r_rptr] : 1'b0;
  end

  // In-flight pipeline shift: one valid/write-tag pair per RAM latency stage
  always_comb begin
    w_pipe_vld_d    = '0;
    w_pipe_wr_d     = '0;
    w_pipe_vld_d[0] = w_accept;
    w_pipe_wr_d[0]  = bus.req_we;
    for (int i = 1; i < int'(LAT); i++) begin
      w_pipe_vld_d[i] = r_pipe_vld[i-1];
      w_pipe_wr_d[i]  = r_pipe_wr[i-1];
    end
  end

  // Control state: pipeline, FIFO pointers and occupancy, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pipe_vld <= '0;
      r_pipe_wr  <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= 5'd0;
    end else begin
      r_pipe_vld <= w_pipe_vld_d;
      r_pipe_wr  <= w_pipe_wr_d;
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage: the exiting pipeline stage captures RAM data (or zero for a write)
  always_ff @(posedge clk) begin
    if (rstn && w_push) begin
      r_fifo_data[r_wptr] <= w_push_data;
      r_fifo_wr[r_wptr]   <= r_pipe_wr[LAT-1];
    end
  end

  // The credit rule must keep the FIFO from ever taking a push while full
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(w_push && !w_pop && (r_count == DEPTH_C)));

endmodule

// File: tb/tb_dualmem_req_bridge.sv
// Scoreboard bench for dualmem_req_bridge. It models the RAM itself, including the
// optional DUALMEM_OUTREG_EN output register. A reference memory is updated at request
// acceptance and supplies the expected responses in acceptance order.
module tb_dualmem_req_bridge;
`ifdef DUALMEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = 4;

  typedef struct {
    logic        wr;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   last_acc_cyc = 0;
  bit   rand_rdy = 1'b0;

  exp_t        exp_q[$];
  logic [63:0] ram_mem [2048];
  logic [63:0] ref_mem [2048];
  logic [63:0] rd1, rd2;

  bit          hold;
  logic [63:0] hold_data;
  logic        hold_wr;

  dualmem_req_bridge_if #(.ADDR_W(11)) bus ();

  dualmem_req_bridge #(.ADDR_W(11), .RSP_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: byte-enabled write, registered read
  always @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (bus.ram_en[b] && bus.ram_we[b]) ram_mem[bus.ram_addr][b*8 +: 8] <= bus.ram_wdata[b*8 +: 8];
    end
    if (bus.ram_en == 8'hFF && bus.ram_we == 8'h00) rd1 <= ram_mem[bus.ram_addr];
    rd2 <= rd1;
  end
`ifdef DUALMEM_OUTREG_EN
  assign bus.ram_rdata = rd2;
`else
  assign bus.ram_rdata = rd1;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: reset checks, response scoreboard, stability, and RAM drive at acceptance
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
      chk("rst_rsp_write", 64'(bus.rsp_write), 64'd0);
      chk("rst_ram_en", 64'(bus.ram_en), 64'd0);
      chk("rst_ram_we", 64'(bus.ram_we), 64'd0);
      exp_q.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
        chk("hold_rdata", bus.rsp_rdata, hold_data);
        chk("hold_write", 64'(bus.rsp_write), 64'(hold_wr));
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_write", 64'(bus.rsp_write), 64'(e.wr));
          chk("rsp_rdata", bus.rsp_rdata, e.data);
        end
      end
      hold      = bus.rsp_valid && !bus.rsp_ready;
      hold_data = bus.rsp_rdata;
      hold_wr   = bus.rsp_write;

      if (bus.req_valid && bus.req_ready) begin
        exp_t e;
        last_acc_cyc = cyc;
        if (bus.req_we) begin
          chk("ram_en_wr", 64'(bus.ram_en), 64'(bus.req_be));
          chk("ram_we_wr", 64'(bus.ram_we), 64'(bus.req_be));
          if (bus.req_be != 8'h00) begin
            chk("ram_addr_wr", 64'(bus.ram_addr), 64'(bus.req_addr));
            chk("ram_wdata", bus.ram_wdata, bus.req_wdata);
          end
          for (int b = 0; b < 8; b++) begin
            if (bus.req_be[b]) ref_mem[bus.req_addr][b*8 +: 8] = bus.req_wdata[b*8 +: 8];
          end
          e.wr   = 1'b1;
          e.data = 64'd0;
        end else begin
          chk("ram_en_rd", 64'(bus.ram_en), 64'hFF);
          chk("ram_we_rd", 64'(bus.ram_we), 64'd0);
          chk("ram_addr_rd", 64'(bus.ram_addr), 64'(bus.req_addr));
          e.wr   = 1'b0;
          e.data = ref_mem[bus.req_addr];
        end
        exp_q.push_back(e);
      end else begin
        chk("idle_ram_en", 64'(bus.ram_en), 64'd0);
        chk("idle_ram_we", 64'(bus.ram_we), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic we, input logic [10:0] a, input logic [7:0] be,
                       input logic [63:0] d);
    bit ok;
    ok            = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_be    = be;
    bus.req_wdata = d;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = bus.req_ready;
      tick();
    end
    if (!ok) chk("issue_timeout", 64'(ok), 64'd1);
    bus.req_valid = 1'b0;
  endtask

  // Waits for the response of a lone request and checks acceptance-to-valid latency
  task automatic check_latency(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        seen = 1'b1;
        chk(name, 64'(cyc - last_acc_cyc), 64'(LAT + 1));
      end
      tick();
    end
    if (!seen) chk({name, "_timeout"}, 64'(seen), 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick();
    tick();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    int a;
    bit acc;
    for (int i = 0; i < 2048; i++) begin
      ram_mem[i] = {$urandom, $urandom};
      ref_mem[i] = ram_mem[i];
    end
    rstn          = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 11'd0;
    bus.req_be    = 8'h00;
    bus.req_wdata = 64'd0;
    bus.rsp_ready = 1'b1;

    // Reset with a pending request, then ready on the first released cycle
    repeat (3) tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = 1'b0;
    drain();

    // Directed write/read, partial write, zero-strobe write
    issue(1'b1, 11'h010, 8'hFF, 64'h0123456789ABCDEF);
    check_latency("lat_write");
    issue(1'b0, 11'h010, 8'h00, 64'd0);
    check_latency("lat_read");
    issue(1'b1, 11'h010, 8'h0F, 64'hFFFFFFFF_AAAAAAAA);
    check_latency("lat_pwrite");
    issue(1'b0, 11'h010, 8'h00, 64'd0);
    check_latency("lat_pread");
    issue(1'b1, 11'h010, 8'h00, 64'hDEADBEEF_DEADBEEF);
    check_latency("lat_be0");
    issue(1'b0, 11'h010, 8'h00, 64'd0);
    check_latency("lat_read_be0");
    drain();

    // Back-pressure: only DEPTH reads fit while the consumer stalls
    bus.rsp_ready = 1'b0;
    a             = 1;
    n_acc         = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 11'(a);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      acc = bus.req_ready;
      if (acc) n_acc++;
      tick();
      if (acc) begin
        a++;
        bus.req_addr = 11'(a);
      end
    end
    chk("bp_accepted", 64'(n_acc), 64'(DEPTH));
    @(negedge clk);
    chk("bp_ready_low", 64'(bus.req_ready), 64'd0);
    tick();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = a; i <= 8; i++) issue(1'b0, 11'(i), 8'h00, 64'd0);
    drain();

    // Throughput and pointer wrap: 64 back-to-back reads
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    for (int i = 0; i < 64; i++) begin
      bus.req_addr = 11'($urandom_range(0, 2047));
      @(negedge clk);
      chk("tput_ready", 64'(bus.req_ready), 64'd1);
      tick();
    end
    bus.req_valid = 1'b0;
    drain();

    // Randomized mix with a randomly stalling consumer
    rand_rdy = 1'b1;
    for (int i = 0; i < 250; i++) begin
      issue(($urandom_range(0, 2) == 0), 11'($urandom_range(0, 31)),
            ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom), {$urandom, $urandom});
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_rdy      = 1'b0;
    bus.rsp_ready = 1'b1;
    drain();

    // Reset while reads are in flight and buffered
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(1'b0, 11'(20 + i), 8'h00, 64'd0);
    rstn = 1'b0;
    repeat (2) tick();
    rstn          = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      tick();
    end
    issue(1'b0, 11'h010, 8'h00, 64'd0);
    check_latency("lat_after_reset");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
